// File: rtl/usb_reset_sequencer.sv
// Turns the SoC's USB reset request level into a timed active-low reset for the
// external USB controller, with a minimum assertion width and a recovery window.
module usb_reset_sequencer #(
  parameter int ASSERT_CYCLES  = 8,
  parameter int RECOVER_CYCLES = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_in,
  output logic       usb_rst_n,
  output logic       ready,
  output logic       busy,
  output logic       done_pulse,
  output logic [7:0] rst_count
);

  localparam int MAX_CYCLES = (ASSERT_CYCLES > RECOVER_CYCLES) ? ASSERT_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0] ASSERT_LOAD  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RECOVER = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             count_inc;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  logic usb_rst_n_next;
  logic ready_next;
  logic busy_next;
  logic done_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_ASSERT;
      cnt   <= ASSERT_LOAD;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ASSERT finishes its minimum count before looking at the request, so a
  // request arriving while already asserted is absorbed without a reload.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    count_inc  = 1'b0;
    case (state)
      ST_ASSERT: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end else if (!req_s) begin
          state_next = ST_RECOVER;
          cnt_next   = RECOVER_LOAD;
        end
      end
      ST_RECOVER: begin
        if (req_s) begin
          state_next = ST_ASSERT;
          cnt_next   = ASSERT_LOAD;
          count_inc  = 1'b1;
        end else if (cnt != '0) begin
          cnt_next = cnt - CNT_ONE;
        end else begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        if (req_s) begin
          state_next = ST_ASSERT;
          cnt_next   = ASSERT_LOAD;
          count_inc  = 1'b1;
        end
      end
      default: begin
        state_next = ST_ASSERT;
        cnt_next   = ASSERT_LOAD;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered so the controller's
  // reset pin never sees a multi-bit state transition glitch.
  always_comb begin
    usb_rst_n_next = (state_next != ST_ASSERT);
    ready_next     = (state_next == ST_READY);
    busy_next      = (state_next != ST_READY);
    done_next      = (state_next == ST_READY) && (state != ST_READY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      usb_rst_n  <= 1'b0;
      ready      <= 1'b0;
      busy       <= 1'b1;
      done_pulse <= 1'b0;
    end else begin
      usb_rst_n  <= usb_rst_n_next;
      ready      <= ready_next;
      busy       <= busy_next;
      done_pulse <= done_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_count <= 8'd0;
    end else if (count_inc && (rst_count != 8'hFF)) begin
      rst_count <= rst_count + 8'd1;
    end
  end

endmodule
